// File: rtl/psx_pad_responder.sv
// PSX pad end: decodes host CMD and returns pad bytes on DAT, LSB first; input latency SYNC_STAGES+1 clk.
// No backpressure: the host paces bits, and the pad holds the host between bytes only through ack_n.
module psx_pad_responder #(
  parameter int ACK_DELAY   = 4,
  parameter int ACK_WIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        att_n,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] buttons,
  input  logic        analog_mode,
  input  logic [7:0]  stick_rx,
  input  logic [7:0]  stick_ry,
  input  logic [7:0]  stick_lx,
  input  logic [7:0]  stick_ly,
  output logic        dat,
  output logic        ack_n,
  output logic [3:0]  byte_idx,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        frame_done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_PULSE, TAIL, IGNORE} state_t;

  localparam logic [15:0] DELAY_LAST = 16'(ACK_DELAY - 1);
  localparam logic [15:0] WIDTH_LAST = 16'(ACK_WIDTH - 1);

  logic [SYNC_STAGES-1:0] att_sync, clk_sync, cmd_sync;
  logic                   att_prev, clk_prev;
  logic                   att_s, clk_s, cmd_s;
  logic                   att_fall, att_rise, clk_fall, clk_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      att_sync <= '1;
      clk_sync <= '1;
      cmd_sync <= '1;
      att_prev <= 1'b1;
      clk_prev <= 1'b1;
    end else begin
      att_sync <= {att_sync[SYNC_STAGES-2:0], att_n};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], psx_clk};
      cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], cmd};
      att_prev <= att_s;
      clk_prev <= clk_s;
    end
  end

  assign att_s    = att_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cmd_s    = cmd_sync[SYNC_STAGES-1];
  assign att_fall = att_prev & ~att_s;
  assign att_rise = ~att_prev & att_s;
  assign clk_fall = clk_prev & ~clk_s;
  assign clk_rise = ~clk_prev & clk_s;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [15:0] cnt;
  logic        analog_q;
  logic [15:0] btn_q;
  logic [31:0] stick_q;
  logic [7:0]  rx_next, cur_tx, nxt_tx;
  logic [3:0]  last_idx;

  function automatic logic [7:0] pad_byte(input logic [3:0] idx, input logic an,
                                          input logic [15:0] btn, input logic [31:0] st);
    case (idx)
      4'd0:    pad_byte = 8'hFF;
      4'd1:    pad_byte = an ? 8'h73 : 8'h41;
      4'd2:    pad_byte = 8'h5A;
      4'd3:    pad_byte = ~btn[7:0];
      4'd4:    pad_byte = ~btn[15:8];
      4'd5:    pad_byte = st[31:24];
      4'd6:    pad_byte = st[23:16];
      4'd7:    pad_byte = st[15:8];
      4'd8:    pad_byte = st[7:0];
      default: pad_byte = 8'hFF;
    endcase
  endfunction

  assign rx_next  = {cmd_s, rx_sr};
  assign cur_tx   = pad_byte(byte_idx, analog_q, btn_q, stick_q);
  assign nxt_tx   = pad_byte(byte_idx + 4'd1, analog_q, btn_q, stick_q);
  assign last_idx = analog_q ? 4'd8 : 4'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dat        <= 1'b1;
      ack_n      <= 1'b1;
      byte_idx   <= 4'd0;
      rx_byte    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      bit_cnt    <= 3'd0;
      rx_sr      <= 7'd0;
      cnt        <= 16'd0;
      analog_q   <= 1'b0;
      btn_q      <= 16'd0;
      stick_q    <= 32'd0;
    end else begin
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      // Deselect overrides everything; abandoning an unfinished frame is an error.
      if (att_rise) begin
        state    <= IDLE;
        dat      <= 1'b1;
        ack_n    <= 1'b1;
        byte_idx <= 4'd0;
        if (state inside {SHIFT, ACK_WAIT, ACK_PULSE}) err <= 1'b1;
      end else begin
        case (state)
          IDLE: if (att_fall) begin
            state    <= SHIFT;
            analog_q <= analog_mode;
            bit_cnt  <= 3'd0;
            byte_idx <= 4'd0;
            dat      <= 1'b1;
          end
          SHIFT: if (clk_rise) begin
            rx_sr   <= rx_next[7:1];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_byte  <= rx_next;
              rx_valid <= 1'b1;
              if (byte_idx == 4'd2) begin
                btn_q   <= buttons;
                stick_q <= {stick_rx, stick_ry, stick_lx, stick_ly};
              end
              if ((byte_idx == 4'd0 && rx_next != 8'h01) ||
                  (byte_idx == 4'd1 && rx_next != 8'h42)) begin
                err   <= 1'b1;
                state <= IGNORE;
                dat   <= 1'b1;
              end else if (byte_idx == last_idx) begin
                frame_done <= 1'b1;
                state      <= TAIL;
                dat        <= 1'b1;
              end else begin
                state <= ACK_WAIT;
                cnt   <= 16'd0;
              end
            end
          end else if (clk_fall) begin
            dat <= cur_tx[bit_cnt];
          end
          ACK_WAIT: if (clk_rise || clk_fall) begin
            err   <= 1'b1;
            state <= IGNORE;
            dat   <= 1'b1;
          end else if (cnt == DELAY_LAST) begin
            state <= ACK_PULSE;
            ack_n <= 1'b0;
            cnt   <= 16'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
          ACK_PULSE: if (clk_rise || clk_fall) begin
            err   <= 1'b1;
            state <= IGNORE;
            dat   <= 1'b1;
            ack_n <= 1'b1;
          end else if (cnt == WIDTH_LAST) begin
            state    <= SHIFT;
            ack_n    <= 1'b1;
            byte_idx <= byte_idx + 4'd1;
            bit_cnt  <= 3'd0;
            dat      <= nxt_tx[0];
          end else begin
            cnt <= cnt + 16'd1;
          end
          TAIL, IGNORE: begin
            dat   <= 1'b1;
            ack_n <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_psx_pad_responder.sv
// Bench for psx_pad_responder: a host model clocks frames and compares pad bytes and
// per-cycle handshake behaviour against a byte-level model of the pad.
module tb_psx_pad_responder;
  localparam int ACK_DELAY = 4;
  localparam int ACK_WIDTH = 4;
  localparam int H         = 8;

  logic        clk = 1'b0;
  logic        rst, att_n, psx_clk, cmd, analog_mode;
  logic [15:0] buttons;
  logic [7:0]  stick_rx, stick_ry, stick_lx, stick_ly;
  logic        dat, ack_n, rx_valid, frame_done, err;
  logic [3:0]  byte_idx;
  logic [7:0]  rx_byte;

  int n_chk = 0, n_pass = 0;
  int mon_acks = 0, mon_fd = 0, mon_err = 0;
  int since_rx = 1000, low_w = 0, att_hi = 0;
  logic ack_prev_m = 1'b1;
  logic [11:0] mon_e;
  logic [11:0] exp_q[$];
  logic [7:0]  got_bytes[9];
  logic [7:0]  lit[9];

  psx_pad_responder #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .att_n(att_n), .psx_clk(psx_clk), .cmd(cmd),
    .buttons(buttons), .analog_mode(analog_mode),
    .stick_rx(stick_rx), .stick_ry(stick_ry), .stick_lx(stick_lx), .stick_ly(stick_ly),
    .dat(dat), .ack_n(ack_n), .byte_idx(byte_idx), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle compare against the handshake rules
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      ack_prev_m = 1'b1;
      since_rx   = 1000;
      low_w      = 0;
      att_hi     = 0;
    end else begin
      since_rx++;
      if (rx_valid) begin
        check("rx_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("rx_byte", rx_byte, mon_e[7:0]);
          check("rx_idx", byte_idx, mon_e[11:8]);
        end
        since_rx = 0;
      end
      if (ack_prev_m && !ack_n) begin
        check("ack_delay", since_rx, ACK_DELAY);
        low_w = 0;
      end
      if (!ack_n) low_w++;
      if (!ack_prev_m && ack_n) begin
        check("ack_width", low_w, ACK_WIDTH);
        mon_acks++;
      end
      ack_prev_m = ack_n;
      if (frame_done) mon_fd++;
      if (err) mon_err++;
      att_hi = att_n ? att_hi + 1 : 0;
      if (att_hi > 6) check("idle_outputs", {dat, ack_n, byte_idx}, 6'h30);
    end
  end

  task automatic wait_ack_fall(output bit ok);
    int n = 0;
    while (ack_n && n < 100) begin @(negedge clk); n++; end
    ok = !ack_n;
  endtask

  task automatic wait_ack(output bit ok);
    int n = 0;
    wait_ack_fall(ok);
    if (ok) begin
      while (!ack_n && n < 100) begin @(negedge clk); n++; end
      ok = ack_n;
    end
  endtask

  // mode 0: full frame, 1: deselect after 3 bits of byte 2, 2: reset during first ack pulse
  task automatic run_frame(input int mode, input logic an, input logic [15:0] btn,
                           input logic [31:0] st, input logic [7:0] c0, input logic [7:0] c1,
                           input bit rnd, input bit chg);
    logic [7:0] cmdb[9];
    logic [7:0] exptx[9];
    logic [7:0] got;
    int len, nclk, err_at, nrx, acks_exp, fd_exp, err_exp, a0, f0, e0;
    bit aborted, reset_done, acked, ok;
    len = an ? 9 : 5;
    cmdb[0] = c0;
    cmdb[1] = c1;
    for (int i = 2; i < 9; i++) cmdb[i] = rnd ? 8'($urandom) : 8'h00;
    err_at = (c0 != 8'h01) ? 0 : (c1 != 8'h42) ? 1 : -1;
    exptx[0] = 8'hFF;
    exptx[1] = an ? 8'h73 : 8'h41;
    exptx[2] = 8'h5A;
    exptx[3] = ~btn[7:0];
    exptx[4] = ~btn[15:8];
    exptx[5] = st[31:24];
    exptx[6] = st[23:16];
    exptx[7] = st[15:8];
    exptx[8] = st[7:0];
    if (err_at >= 0) exptx[err_at+1] = 8'hFF;
    nclk     = (err_at >= 0) ? err_at + 2 : len;
    nrx      = (err_at >= 0) ? err_at + 1 : len;
    acks_exp = (err_at >= 0) ? err_at : len - 1;
    fd_exp   = (err_at < 0 && mode == 0) ? 1 : 0;
    err_exp  = (err_at >= 0 || mode == 1) ? 1 : 0;
    if (mode == 1) begin nrx = 2; acks_exp = 2; end
    if (mode == 2) begin nrx = 1; acks_exp = 0; end
    for (int i = 0; i < nrx; i++) exp_q.push_back({4'(i), cmdb[i]});

    analog_mode = an;
    buttons     = btn;
    {stick_rx, stick_ry, stick_lx, stick_ly} = st;
    a0 = mon_acks; f0 = mon_fd; e0 = mon_err;
    aborted = 0; reset_done = 0;
    att_n = 1'b0;
    wait_cycles(10);
    for (int b = 0; b < nclk; b++) begin
      got = 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (mode == 1 && b == 2 && k == 3) begin aborted = 1; break; end
        psx_clk = 1'b0;
        cmd     = cmdb[b][k];
        wait_cycles(H);
        psx_clk = 1'b1;
        got[k]  = dat;
        if (k < 7) wait_cycles(H);
      end
      if (aborted) begin att_n = 1'b1; break; end
      got_bytes[b] = got;
      check($sformatf("tx_byte%0d", b), got, exptx[b]);
      acked = (b < len - 1) && (err_at < 0 || b < err_at);
      if (mode == 2 && b == 0) begin
        wait_ack_fall(ok);
        check("ack_fall_seen", ok, 1);
        wait_cycles(1);
        rst   = 1'b1;
        att_n = 1'b1;
        #1;
        check("rst_async_ack_n", ack_n, 1);
        check("rst_async_dat", dat, 1);
        wait_cycles(1);
        check("rst_state", {byte_idx, rx_byte, rx_valid, frame_done, err}, 15'h0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(10);
        reset_done = 1;
        break;
      end
      if (acked) begin
        wait_ack(ok);
        check($sformatf("ack_seen%0d", b), ok, 1);
        wait_cycles(H);
      end else begin
        wait_cycles(3 * H);
      end
      if (chg && b == 2) begin
        buttons     = 16'($urandom);
        {stick_rx, stick_ry, stick_lx, stick_ly} = $urandom;
        analog_mode = ~an;
      end
    end
    cmd = 1'b1;
    if (aborted) begin
      wait_cycles(5);
      check("abort_idle", {dat, ack_n, byte_idx}, 6'h30);
      wait_cycles(10);
    end else if (!reset_done) begin
      wait_cycles(4);
      check("tail_idle", {dat, ack_n}, 2'b11);
      att_n = 1'b1;
      wait_cycles(10);
    end
    check("ack_count", mon_acks - a0, acks_exp);
    check("frame_done_count", mon_fd - f0, fd_exp);
    check("err_count", mon_err - e0, err_exp);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; att_n = 1'b1; psx_clk = 1'b1; cmd = 1'b1; analog_mode = 1'b0;
    buttons = 16'h0; stick_rx = 8'h0; stick_ry = 8'h0; stick_lx = 8'h0; stick_ly = 8'h0;
    #2;
    check("reset_outputs", {dat, ack_n, byte_idx, rx_byte, rx_valid, frame_done, err}, 17'h18000);
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(10);

    run_frame(0, 1'b0, 16'h0001, $urandom, 8'h01, 8'h42, 0, 0);
    lit[0] = 8'hFF; lit[1] = 8'h41; lit[2] = 8'h5A; lit[3] = 8'hFE; lit[4] = 8'hFF;
    for (int i = 0; i < 5; i++) check($sformatf("digital_lit%0d", i), got_bytes[i], lit[i]);

    run_frame(0, 1'b1, 16'h1234, 32'h807F00FF, 8'h01, 8'h42, 1, 1);
    lit[0] = 8'hFF; lit[1] = 8'h73; lit[2] = 8'h5A; lit[3] = 8'hCB; lit[4] = 8'hED;
    lit[5] = 8'h80; lit[6] = 8'h7F; lit[7] = 8'h00; lit[8] = 8'hFF;
    for (int i = 0; i < 9; i++) check($sformatf("analog_lit%0d", i), got_bytes[i], lit[i]);

    run_frame(0, 1'b0, 16'($urandom), $urandom, 8'h03, 8'h42, 1, 0);
    lit[1] = 8'hFF;
    check("bad_cmd_dat_idle", got_bytes[1], lit[1]);
    run_frame(0, 1'b0, 16'($urandom), $urandom, 8'h01, 8'h42, 1, 0);
    run_frame(0, 1'b1, 16'($urandom), $urandom, 8'h01, 8'h43, 1, 0);
    run_frame(1, 1'b1, 16'($urandom), $urandom, 8'h01, 8'h42, 1, 0);
    run_frame(0, 1'b0, 16'($urandom), $urandom, 8'h01, 8'h42, 1, 1);
    run_frame(2, 1'b0, 16'($urandom), $urandom, 8'h01, 8'h42, 1, 0);
    run_frame(0, 1'b1, 16'($urandom), $urandom, 8'h01, 8'h42, 1, 0);

    for (int f = 0; f < 8; f++)
      run_frame(0, 1'($urandom), 16'($urandom), $urandom, 8'h01, 8'h42, 1, 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
